// File: rtl/mdio_pkg.sv
// mdio_pkg: shared state/source types, opcodes, the PHY init ROM and the Clause-22 frame builder.
package mdio_pkg;
  typedef enum logic [2:0] {WAIT_PHY, STARTUP, IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SRC_INIT, SRC_USER, SRC_POLL} src_t;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] INIT_LEN = 2'd2;
  localparam logic [4:0] BMSR_ADDR = 5'd1;
  localparam int BMSR_LINK_BIT = 2;
  function automatic logic [20:0] init_entry(input logic [1:0] idx);
    return idx == 2'd0 ? {5'd0, 16'h1140} : {5'd0, 16'h1340};
  endfunction
  // Reads carry TA=10 and zero data too; the shifter releases the line for those bits.
  function automatic logic [63:0] mk_frame(input logic [1:0] op, input logic [4:0] phyad,
                                           input logic [4:0] regad, input logic [15:0] data);
    return {32'hFFFF_FFFF, 2'b01, op, phyad, regad, 2'b10, data};
  endfunction
endpackage

// File: rtl/mdio_shifter.sv
// mdio_shifter: MDC divider, 64-bit MDIO frame shifter, tristate control and read-data capture.
module mdio_shifter #(
  parameter int CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic        is_read,
  input  logic [63:0] frame,
  input  logic        mdio_i,
  output logic        done,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [15:0] rdata
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div;
  logic [5:0] cnt;
  logic [62:0] sr;
  logic active, rd, tick;
  assign tick = active && div == DW'(CLK_DIV - 1);
  assign done = tick && mdc && cnt == 6'd63;
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      div <= '0;
      cnt <= '0;
      active <= 1'b0;
      rd <= 1'b0;
      mdc <= 1'b0;
      mdio_o <= 1'b1;
      mdio_oe <= 1'b0;
      if (rst) rdata <= '0;
    end else if (start) begin
      sr <= frame[62:0];
      mdio_o <= frame[63];
      mdio_oe <= 1'b1;
      rd <= is_read;
      cnt <= '0;
      div <= '0;
      mdc <= 1'b0;
      active <= 1'b1;
    end else if (active) begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        mdc <= !mdc;
        if (!mdc) begin
          if (rd && cnt >= 6'd48) rdata <= {rdata[14:0], mdio_i};
        end else if (cnt == 6'd63) begin
          active <= 1'b0;
          mdio_o <= 1'b1;
          mdio_oe <= 1'b1;
        end else begin
          // Next bit goes out on the falling MDC edge; reads release the line from TA onward.
          cnt <= cnt + 6'd1;
          sr <= {sr[61:0], 1'b0};
          mdio_o <= sr[62];
          mdio_oe <= !(rd && cnt >= 6'd45);
        end
      end
    end else begin
      mdio_o <= 1'b1;
      mdio_oe <= 1'b1;
    end
  end
endmodule

// File: rtl/mdio_phy_config.sv
// mdio_phy_config: Clause-22 MDIO controller running PHY init, user accesses and periodic BMSR polling.
module mdio_phy_config
  import mdio_pkg::*;
#(
  parameter int         CLK_DIV        = 50,
  parameter logic [4:0] PHY_ADDR       = 5'd1,
  parameter int         STARTUP_CYCLES = 1_250_000,
  parameter int         POLL_CYCLES    = 12_500_000
) (
  input  logic        clk125MHz,
  input  logic        rst,
  input  logic        phy_ready,
  input  logic        req,
  input  logic        req_we,
  input  logic [4:0]  req_regad,
  input  logic [15:0] req_wdata,
  output logic        req_ack,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        init_done,
  output logic        link_up,
  output logic        eth_mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  state_t state;
  src_t src;
  logic [1:0] idx;
  logic [31:0] su_cnt, poll_cnt;
  logic poll_pending, rd_q, start, is_read, done, init_sel, user_sel;
  logic [63:0] frame;
  logic [20:0] rom;
  logic [15:0] sh_rdata;
  assign rom = init_entry(idx);
  assign init_sel = idx < INIT_LEN;
  assign user_sel = req && init_done;
  assign start = state == IDLE && phy_ready && (init_sel || user_sel || poll_pending);
  assign is_read = !init_sel && !(user_sel && req_we);
  assign frame = init_sel ? mk_frame(OP_WR, PHY_ADDR, rom[20:16], rom[15:0])
               : user_sel ? mk_frame(req_we ? OP_WR : OP_RD, PHY_ADDR, req_regad, req_we ? req_wdata : 16'h0)
               : mk_frame(OP_RD, PHY_ADDR, BMSR_ADDR, 16'h0);
  mdio_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk(clk125MHz),
    .rst(rst),
    .abort(!phy_ready),
    .start(start),
    .is_read(is_read),
    .frame(frame),
    .mdio_i(mdio_i),
    .done(done),
    .mdc(eth_mdc),
    .mdio_o(mdio_o),
    .mdio_oe(mdio_oe),
    .rdata(sh_rdata)
  );
  always_ff @(posedge clk125MHz) begin
    req_ack <= 1'b0;
    rdata_valid <= 1'b0;
    if (rst || !phy_ready) begin
      state <= WAIT_PHY;
      idx <= '0;
      init_done <= 1'b0;
      link_up <= 1'b0;
      poll_pending <= 1'b0;
      busy <= 1'b0;
      su_cnt <= '0;
      poll_cnt <= '0;
      if (rst) rdata <= '0;
    end else begin
      poll_cnt <= !init_done || poll_cnt == POLL_CYCLES - 1 ? '0 : poll_cnt + 32'd1;
      case (state)
        WAIT_PHY: begin
          su_cnt <= '0;
          state <= STARTUP;
        end
        STARTUP: begin
          su_cnt <= su_cnt + 32'd1;
          if (su_cnt == STARTUP_CYCLES - 1) state <= IDLE;
        end
        IDLE: if (start) begin
          state <= SHIFT;
          busy <= 1'b1;
          rd_q <= is_read;
          src <= init_sel ? SRC_INIT : user_sel ? SRC_USER : SRC_POLL;
        end
        SHIFT: if (done) state <= DONE;
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          if (src == SRC_INIT) begin
            idx <= idx + 2'd1;
            if (idx + 2'd1 == INIT_LEN) init_done <= 1'b1;
          end else if (src == SRC_USER) begin
            req_ack <= 1'b1;
            rdata_valid <= rd_q;
            if (rd_q) rdata <= sh_rdata;
          end else begin
            poll_pending <= 1'b0;
            link_up <= sh_rdata[BMSR_LINK_BIT];
            rdata <= sh_rdata;
          end
        end
        default: state <= WAIT_PHY;
      endcase
      // A timer expiry coinciding with a poll's DONE must not be lost.
      if (init_done && poll_cnt == POLL_CYCLES - 1) poll_pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mdio_phy_config.sv
// tb_mdio_phy_config: scoreboard bench; a PHY model decodes MDIO frames and answers reads.
`timescale 1ns/1ps
module tb_mdio_phy_config;
  logic clk = 1'b0, rst = 1'b1, phy_ready = 1'b0, req = 1'b0, req_we = 1'b0, mdio_i = 1'b1;
  logic [4:0] req_regad = '0;
  logic [15:0] req_wdata = '0;
  logic req_ack, rdata_valid, busy, init_done, link_up, eth_mdc, mdio_o, mdio_oe;
  logic [15:0] rdata;
  int n_vec = 0, n_err = 0, cyc = 0, frames_done = 0, bitn = 0, t_done = 0;
  logic [15:0] phy_bmsr = 16'h796D, phy_user = 16'hABCD, rd_data = 16'h0;
  logic [63:0] got = '0;
  logic [1:0] op = 2'b00;
  logic prev_mdc = 1'b0, prev_init = 1'b0, oe_ok = 1'b1;
  typedef struct {logic [63:0] f; logic rd;} frm_t;
  typedef struct {logic rd; logic [15:0] d;} rsp_t;
  frm_t exp_f[$];
  rsp_t exp_r[$];
  frm_t e;
  rsp_t r;

  mdio_phy_config #(.CLK_DIV(2), .PHY_ADDR(5'd1), .STARTUP_CYCLES(10), .POLL_CYCLES(2000)) dut (
    .clk125MHz(clk), .rst(rst), .phy_ready(phy_ready), .req(req), .req_we(req_we),
    .req_regad(req_regad), .req_wdata(req_wdata), .req_ack(req_ack), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .init_done(init_done), .link_up(link_up),
    .eth_mdc(eth_mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] fr(input logic [1:0] o, input logic [4:0] ra, input logic [15:0] d);
    return {32'hFFFF_FFFF, 2'b01, o, 5'd1, ra, 2'b10, d};
  endfunction
  function automatic void push_wr(input logic [4:0] ra, input logic [15:0] d);
    exp_f.push_back('{fr(2'b01, ra, d), 1'b0});
  endfunction
  function automatic void push_rd(input logic [4:0] ra);
    exp_f.push_back('{fr(2'b10, ra, 16'h0), 1'b1});
  endfunction

  // PHY model + frame scoreboard + response scoreboard
  always @(negedge clk) begin
    if (!busy) begin
      bitn = 0;
      op = 2'b00;
      oe_ok = 1'b1;
    end else if (eth_mdc && !prev_mdc && bitn < 64) begin
      oe_ok = oe_ok && (mdio_oe === !(bitn >= 46 && op == 2'b10));
      got = {got[62:0], mdio_o};
      if (bitn == 35) op = got[1:0];
      if (bitn == 45) rd_data = got[4:0] == 5'd1 ? phy_bmsr : phy_user;
      bitn++;
      if (bitn == 64) begin
        frames_done++;
        chk("frame_expected", exp_f.size() != 0, 1);
        if (exp_f.size() != 0) begin
          e = exp_f.pop_front();
          chk(e.rd ? "rd_frame_hdr" : "wr_frame", e.rd ? got >> 18 : got, e.rd ? e.f >> 18 : e.f);
          chk("frame_oe", oe_ok, 1);
        end
      end
    end
    mdio_i = (busy && op == 2'b10 && bitn >= 48 && bitn < 64) ? rd_data[63 - bitn] : 1'b1;
    if (req_ack) begin
      chk("ack_expected", exp_r.size() != 0, 1);
      if (exp_r.size() != 0) begin
        r = exp_r.pop_front();
        chk("ack_after_init", init_done, 1);
        chk("rdata_valid", rdata_valid, r.rd);
        if (r.rd) chk("user_rdata", rdata, r.d);
      end
    end else if (rdata_valid) chk("rdata_valid_no_ack", rdata_valid, 0);
    if (init_done && !prev_init) t_done = cyc;
    prev_init = init_done;
    prev_mdc = eth_mdc;
  end

  task automatic access(input logic we, input logic [4:0] ra, input logic [15:0] d, input int limit,
                        output int a_c, output int b_c);
    logic pb = busy;
    if (we) push_wr(ra, d); else push_rd(ra);
    exp_r.push_back('{!we, phy_user});
    req = 1'b1; req_we = we; req_regad = ra; req_wdata = d;
    a_c = -1; b_c = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy && !pb) b_c = cyc;
      pb = busy;
      if (req_ack) begin a_c = cyc; break; end
    end
    req = 1'b0;
    chk("ack_seen", a_c >= 0, 1);
  endtask

  task automatic wait_frames(input int n, input int limit);
    int target = frames_done + n;
    for (int i = 0; i < limit && frames_done < target; i++) @(negedge clk);
    chk("frame_arrived", frames_done >= target, 1);
  endtask

  task automatic wait_bit(input int n, input int limit);
    for (int i = 0; i < limit && !(busy && bitn == n); i++) @(negedge clk);
    chk("bit_reached", busy && bitn == n, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mdc"}, eth_mdc, 0);
    chk({tag, "_mdio_o"}, mdio_o, 1);
    chk({tag, "_mdio_oe"}, mdio_oe, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_link_up"}, link_up, 0);
    chk({tag, "_req_ack"}, req_ack, 0);
    chk({tag, "_rdata_valid"}, rdata_valid, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  initial begin
    int a_c, b_c;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    @(negedge clk);
    // init sequence, with a user write pending before init_done
    push_wr(5'd0, 16'h1140);
    push_wr(5'd0, 16'h1340);
    phy_ready = 1'b1;
    access(1'b1, 5'd5, 16'h1234, 3000, a_c, b_c);
    chk("init_done", init_done, 1);
    // user read with latency check
    phy_user = 16'hABCD;
    access(1'b0, 5'd3, 16'h0, 1000, a_c, b_c);
    chk("read_latency", a_c - b_c + 1, 258);
    chk("read_rdata", rdata, 16'hABCD);
    // link polls
    phy_bmsr = 16'h796D;
    push_rd(5'd1);
    wait_frames(1, 3000);
    repeat (4) @(negedge clk);
    chk("link_up_on", link_up, 1);
    chk("poll_rdata", rdata, 16'h796D);
    phy_bmsr = 16'h7969;
    push_rd(5'd1);
    wait_frames(1, 3000);
    repeat (4) @(negedge clk);
    chk("link_up_off", link_up, 0);
    // collision: user req raised in the cycle the poll timer expires
    for (int i = 0; i < 3000 && cyc < t_done + 6000; i++) @(negedge clk);
    chk("collision_align", cyc, t_done + 6000);
    phy_bmsr = 16'h796D;
    access(1'b1, 5'd4, 16'h01E1, 1000, a_c, b_c);
    push_rd(5'd1);
    wait_frames(1, 1000);
    repeat (4) @(negedge clk);
    chk("link_up_after_collision", link_up, 1);
    // abort at bit 20 of a user frame
    req = 1'b1; req_we = 1'b1; req_regad = 5'd6; req_wdata = 16'h5555;
    wait_bit(20, 3000);
    phy_ready = 1'b0;
    @(negedge clk);
    chk("abort_mdc", eth_mdc, 0);
    chk("abort_mdio_oe", mdio_oe, 0);
    chk("abort_init_done", init_done, 0);
    chk("abort_link_up", link_up, 0);
    chk("abort_busy", busy, 0);
    repeat (5) @(negedge clk);
    req = 1'b0;
    push_wr(5'd0, 16'h1140);
    push_wr(5'd0, 16'h1340);
    phy_ready = 1'b1;
    for (int i = 0; i < 1500 && !init_done; i++) @(negedge clk);
    chk("reinit_done", init_done, 1);
    chk("reinit_frames_left", exp_f.size(), 0);
    // reset mid-frame
    req = 1'b1; req_we = 1'b0; req_regad = 5'd7;
    wait_bit(30, 3000);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_mid");
    rst = 1'b0;
    req = 1'b0;
    chk("queues_empty", exp_f.size() + exp_r.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
